axi_sram_slave: RTL and testbench

AXI slave responder that terminates the single-beat AXI traffic produced by the CPU transfer bridge and backs it with an internal byte-writable word RAM. It sits on the far end of the bridge's AR/R/AW/W/B channels and serves as the memory model for CPU bring-up and as the reference target for bridge verification. It supports one outstanding read and one outstanding write, with a programmable read latency.

---
 rtl/axi_sram_slave.sv | 176 +++++++++++++++++
 tb/tb_axi_sram_slave.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_slave
// Description : Single-beat AXI slave backed by a byte-writable 32-bit RAM,
//               one outstanding read (programmable latency) and one write.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_slave #(
    parameter int ADDR_WIDTH = 10,
    parameter int READ_LAT   = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int         c_DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [1:0] c_R_IDLE   = 2'd0;
    localparam logic [1:0] c_R_WAIT   = 2'd1;
    localparam logic [1:0] c_R_RESP   = 2'd2;
    localparam logic [3:0] c_LAT_INIT = 4'(READ_LAT - 1);

    logic [31:0]           r_mem [0:c_DEPTH-1];

    logic [1:0]            r_rstate;
    logic [1:0]            w_rnext;
    logic [3:0]            r_cnt;
    logic [3:0]            r_rid;
    logic [ADDR_WIDTH-1:0] r_ridx;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic [31:0]           r_rdata;
    logic                  w_ar_hs;
    logic                  w_enter_resp;

    logic                  r_aw_held;
    logic                  r_w_held;
    logic                  r_bvalid;
    logic [3:0]            r_awid;
    logic [3:0]            r_bid;
    logic [ADDR_WIDTH-1:0] r_widx;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_commit;
    logic                  w_unused;

    assign w_unused = &{1'b0, araddr[31:ADDR_WIDTH+2], araddr[1:0],
                        awaddr[31:ADDR_WIDTH+2], awaddr[1:0]};

    // ---------------------------------------------------------------- read
    assign w_ar_hs = arvalid && arready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_rstate <= c_R_IDLE;
        else          r_rstate <= w_rnext;
    end

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            c_R_IDLE: if (w_ar_hs)        w_rnext = (READ_LAT == 1) ? c_R_RESP : c_R_WAIT;
            c_R_WAIT: if (r_cnt == 4'd0)  w_rnext = c_R_RESP;
            c_R_RESP: if (rready)         w_rnext = c_R_IDLE;
            default:                      w_rnext = c_R_IDLE;
        endcase
    end

    always_comb begin
        arready = (r_rstate == c_R_IDLE);
        rvalid  = (r_rstate == c_R_RESP);
    end

    // With a one-cycle latency the word is fetched straight from araddr.
    assign w_rd_idx     = (r_rstate == c_R_IDLE) ? araddr[ADDR_WIDTH+1:2] : r_ridx;
    assign w_enter_resp = (r_rstate != c_R_RESP) && (w_rnext == c_R_RESP);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt   <= 4'd0;
            r_rid   <= 4'd0;
            r_ridx  <= '0;
            r_rdata <= 32'd0;
        end else begin
            if (w_ar_hs) begin
                r_rid  <= arid;
                r_ridx <= araddr[ADDR_WIDTH+1:2];
                r_cnt  <= c_LAT_INIT;
            end else if (r_rstate == c_R_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) r_rdata <= r_mem[w_rd_idx];
        end
    end

    assign rid   = r_rid;
    assign rdata = r_rdata;
    assign rresp = 2'b00;
    assign rlast = rvalid;

    // --------------------------------------------------------------- write
    assign awready  = !r_aw_held && !r_bvalid;
    assign wready   = !r_w_held && !r_bvalid;
    assign w_aw_hs  = awvalid && awready;
    assign w_w_hs   = wvalid && wready;
    assign w_b_hs   = r_bvalid && bready;
    assign w_commit = r_aw_held && r_w_held && !r_bvalid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_awid    <= 4'd0;
            r_bid     <= 4'd0;
            r_widx    <= '0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
        end else if (w_b_hs) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awid    <= awid;
                r_widx    <= awaddr[ADDR_WIDTH+1:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bid    <= r_awid;
            end
        end
    end

    // RAM contents survive reset; only the strobed lanes are updated.
    always_ff @(posedge aclk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wstrb[i]) r_mem[r_widx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign bvalid = r_bvalid;
    assign bid    = r_bid;
    assign bresp  = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_sram_slave
// Description : Self-checking bench for axi_sram_slave: vector table, corner
//               sequences and randomized traffic against a word-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;
    localparam int ADDR_WIDTH = 10;
    localparam int READ_LAT   = 2;
    localparam int c_WORDS    = 1 << ADDR_WIDTH;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    always #5 aclk = ~aclk;

    axi_sram_slave #(.ADDR_WIDTH(ADDR_WIDTH), .READ_LAT(READ_LAT)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model    [0:c_WORDS-1];
    bit          model_ok [0:c_WORDS-1];

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or expected read data
        logic [3:0]  strb;
        logic [3:0]  id;
        int          dly;    // read: rready stall cycles
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual=timeout required=handshake at %0t", name, $time);
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % c_WORDS);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        int          w;
        w    = word_of(a);
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        model[w] = (model[w] & ~mask) | (d & mask);
        if (s == 4'hF) model_ok[w] = 1'b1;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [3:0] id, input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0, w_done = 0, a_now, w_now;
        int c = 0;
        while (!(aw_done && w_done)) begin
            if (c > 60) begin
                timeout("write_accept");
                awvalid = 1'b0;
                wvalid  = 1'b0;
                return;
            end
            awvalid = !aw_done && (c >= aw_dly);
            awaddr  = a;
            awid    = id;
            wvalid  = !w_done && (c >= w_dly);
            wdata   = d;
            wstrb   = s;
            if (w_done && !aw_done) check("wready_after_w", wready, 0);
            if (aw_done && !w_done) check("awready_after_aw", awready, 0);
            a_now = awvalid && awready;
            w_now = wvalid && wready;
            @(posedge aclk); #1;
            if (a_now) aw_done = 1;
            if (w_now) w_done = 1;
            c++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("b_not_early", bvalid, 0);
        @(posedge aclk); #1;
        check("b_latency", bvalid, 1);
        c = 0;
        while (!bvalid && c < 20) begin
            @(posedge aclk); #1;
            c++;
        end
        if (!bvalid) begin
            timeout("bvalid");
            return;
        end
        model_write(a, d, s);
        check("bid", bid, id);
        check("bresp", bresp, 0);
        repeat (b_dly) begin
            @(posedge aclk); #1;
            check("bvalid_hold", bvalid, 1);
            check("bid_hold", bid, id);
            check("awready_blocked", awready, 0);
            check("wready_blocked", wready, 0);
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        check("bvalid_clear", bvalid, 0);
        check("awready_reopen", awready, 1);
        check("wready_reopen", wready, 1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [31:0] exp, input int r_dly);
        int c = 0;
        int lat = 0;
        arvalid = 1'b1;
        araddr  = a;
        arid    = id;
        while (!arready) begin
            if (c > 60) begin
                timeout("arready");
                arvalid = 1'b0;
                return;
            end
            @(posedge aclk); #1;
            c++;
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        check("arready_busy", arready, 0);
        while (!rvalid && lat < 40) begin
            @(posedge aclk); #1;
            lat++;
        end
        check("r_latency", lat, READ_LAT);
        if (!rvalid) return;
        check("rdata", rdata, exp);
        check("rid", rid, id);
        check("rlast", rlast, 1);
        check("rresp", rresp, 0);
        repeat (r_dly) begin
            @(posedge aclk); #1;
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", rdata, exp);
            check("rid_hold", rid, id);
            check("arready_stall", arready, 0);
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        check("rvalid_clear", rvalid, 0);
        check("arready_free", arready, 1);
    endtask

    function automatic logic [31:0] rand_addr();
        int w;
        w = (c_WORDS - 8 + int'($urandom_range(0, 15))) % c_WORDS;
        return ($urandom() & 32'hFFFF_F003) | (32'(w) << 2);
    endfunction

    vec_t tbl [14];

    initial begin
        for (int i = 0; i < c_WORDS; i++) begin
            model[i]    = '0;
            model_ok[i] = 1'b0;
        end
        tbl[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 4'd1, 0};
        tbl[1]  = '{1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 4'd1, 0};
        tbl[2]  = '{1'b1, 32'h0000_0104, 32'h1122_3344, 4'hF, 4'd2, 0};
        tbl[3]  = '{1'b1, 32'h0000_0104, 32'hAABB_CCDD, 4'h5, 4'd3, 0};
        tbl[4]  = '{1'b0, 32'h0000_0104, 32'h11BB_33DD, 4'hF, 4'd1, 0};
        tbl[5]  = '{1'b0, 32'h0000_0107, 32'h11BB_33DD, 4'hF, 4'd0, 4};
        tbl[6]  = '{1'b1, 32'h0000_0000, 32'h0000_0005, 4'hF, 4'hF, 0};
        tbl[7]  = '{1'b0, 32'h0000_1000, 32'h0000_0005, 4'hF, 4'd1, 0};
        tbl[8]  = '{1'b0, 32'hFFFF_F103, 32'hDEAD_BEEF, 4'hF, 4'd2, 1};
        tbl[9]  = '{1'b1, 32'h0000_0104, 32'h9900_0000, 4'h8, 4'd5, 1};
        tbl[10] = '{1'b0, 32'h0000_0104, 32'h99BB_33DD, 4'hF, 4'd1, 0};
        tbl[11] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'hF, 4'd7, 0};
        tbl[12] = '{1'b0, 32'h0000_3FFC, 32'h1234_5678, 4'hF, 4'd3, 0};
        tbl[13] = '{1'b0, 32'h0000_0000, 32'h0000_0005, 4'hF, 4'd0, 0};

        // Reset values while held in reset.
        #2;
        check("rst_arready", arready, 1);
        check("rst_awready", awready, 1);
        check("rst_wready", wready, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_ids", {rid, bid}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_resp", {rresp, bresp}, 0);
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].is_wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].id, 0, 0, tbl[i].dly);
            else              do_read(tbl[i].addr, tbl[i].id, tbl[i].data, tbl[i].dly);
        end

        // W three cycles ahead of AW, then B held off for five cycles.
        do_write(32'h0000_0200, 32'hCAFE_F00D, 4'hF, 4'd6, 3, 0, 5);
        do_read(32'h0000_0200, 4'd1, 32'hCAFE_F00D, 0);
        // AW ahead of W.
        do_write(32'h0000_0204, 32'h0BAD_F00D, 4'hF, 4'd9, 0, 2, 0);
        do_read(32'h0000_0204, 4'd0, 32'h0BAD_F00D, 0);

        // Reset during R_WAIT with a half-delivered write pending.
        arvalid = 1'b1; araddr = 32'h100; arid = 4'd1;
        wvalid  = 1'b1; wdata  = 32'h7777_7777; wstrb = 4'hF;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        wvalid  = 1'b0;
        check("pre_rst_wready", wready, 0);
        #1 aresetn = 1'b0;
        #1;
        check("midrst_rvalid", rvalid, 0);
        check("midrst_arready", arready, 1);
        check("midrst_wready", wready, 1);
        check("midrst_rid", rid, 0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (6) begin
            @(posedge aclk); #1;
            check("postrst_no_r", rvalid, 0);
            check("postrst_no_b", bvalid, 0);
        end
        do_read(32'h0000_0100, 4'd1, 32'hDEAD_BEEF, 0);

        // Randomized traffic around the top-of-RAM wrap point.
        for (int it = 0; it < 150; it++) begin
            logic [31:0] wa, ra, d;
            logic [3:0]  s;
            int          k;
            k  = int'($urandom_range(0, 2));
            wa = rand_addr();
            ra = rand_addr();
            d  = $urandom();
            s  = model_ok[word_of(wa)] ? 4'($urandom_range(1, 15)) : 4'hF;
            if (k == 0 || !model_ok[word_of(ra)]) begin
                do_write(wa, d, s, 4'($urandom()), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            end else if (k == 1 || word_of(ra) == word_of(wa)) begin
                do_read(ra, 4'($urandom()), model[word_of(ra)], int'($urandom_range(0, 2)));
            end else begin
                logic [31:0] exp;
                exp = model[word_of(ra)];
                fork
                    do_read(ra, 4'($urandom()), exp, int'($urandom_range(0, 2)));
                    do_write(wa, d, s, 4'($urandom()), int'($urandom_range(0, 2)),
                             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
                join
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
